// File: rtl/alu_writeback_stage.sv
//------------------------------------------------------------------------------
// Module   : alu_writeback_stage
// Brief    : In-order writeback queue behind the ALU with flag commit,
//            flag view for the ALU and result forwarding for pending entries.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_writeback_stage #(
    parameter int DEPTH = 2,
    parameter int RA_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [31:0]              ex_result,
    input  logic [7:0]               ex_flags,
    input  logic [RA_W-1:0]          ex_rd,
    input  logic                     ex_wr_reg,
    input  logic                     ex_wr_flags,
    input  logic                     flush,
    input  logic                     wb_grant,
    output logic                     rf_we,
    output logic [RA_W-1:0]          rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic [7:0]               flags_q,
    output logic [7:0]               flags_view,
    input  logic [RA_W-1:0]          fwd_rs,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [31:0]      r_result   [DEPTH];
    logic [7:0]       r_flags    [DEPTH];
    logic [RA_W-1:0]  r_rd       [DEPTH];
    logic             r_wr_reg   [DEPTH];
    logic             r_wr_flags [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_flags_q;

    logic             w_head_valid;
    logic             w_head_writes_reg;
    logic             w_accept;
    logic             w_retire;
    logic [PTR_W-1:0] w_idx;
    logic             w_fwd_hit;
    logic [31:0]      w_fwd_data;
    logic [7:0]       w_flags_view;

    assign ex_ready          = (r_count < c_depth);
    assign w_head_valid      = (r_count != '0);
    assign w_head_writes_reg = r_wr_reg[r_head] && (r_rd[r_head] != '0);
    assign w_accept          = ex_valid && ex_ready && !flush;
    assign w_retire          = w_head_valid && !flush && (wb_grant || !w_head_writes_reg);

    assign rf_we      = w_head_valid && w_head_writes_reg && wb_grant && !flush;
    assign rf_waddr   = r_rd[r_head];
    assign rf_wdata   = r_result[r_head];
    assign flags_q    = r_flags_q;
    assign flags_view = w_flags_view;
    assign fwd_hit    = w_fwd_hit;
    assign fwd_data   = w_fwd_data;
    assign pending    = r_count;

    // Walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        w_idx        = r_head;
        w_fwd_hit    = 1'b0;
        w_fwd_data   = 32'h0;
        w_flags_view = r_flags_q;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if (CNT_W'(k) < r_count) begin
                if (r_wr_flags[w_idx]) begin
                    w_flags_view = r_flags[w_idx];
                end
                if ((fwd_rs != '0) && r_wr_reg[w_idx] && (r_rd[w_idx] == fwd_rs)) begin
                    w_fwd_hit  = 1'b1;
                    w_fwd_data = r_result[w_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_flags_q <= 8'h00;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_retire) begin
                r_head <= r_head + 1'b1;
                if (r_wr_flags[r_head]) begin
                    r_flags_q <= r_flags[r_head];
                end
            end
            case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is carried by the count.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_result[r_tail]   <= ex_result;
            r_flags[r_tail]    <= ex_flags;
            r_rd[r_tail]       <= ex_rd;
            r_wr_reg[r_tail]   <= ex_wr_reg;
            r_wr_flags[r_tail] <= ex_wr_flags;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_writeback_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_writeback_stage
// Brief    : Directed, table-driven bench for alu_writeback_stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [7:0]  ex_flags;
    logic [4:0]  ex_rd;
    logic        ex_wr_reg;
    logic        ex_wr_flags;
    logic        flush;
    logic        wb_grant;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [7:0]  flags_q;
    logic [7:0]  flags_view;
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [1:0]  pending;

    int total = 0;
    int bad   = 0;

    alu_writeback_stage #(.DEPTH(2), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_result(ex_result), .ex_flags(ex_flags), .ex_rd(ex_rd),
        .ex_wr_reg(ex_wr_reg), .ex_wr_flags(ex_wr_flags),
        .flush(flush), .wb_grant(wb_grant),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flags_q(flags_q), .flags_view(flags_view),
        .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [7:0]  flags;
        logic [4:0]  rd;
        logic        wr_reg;
        logic        wr_flags;
        logic        exp_we;
        logic        exp_hit;
        logic [7:0]  exp_view;
        logic [7:0]  exp_q;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [7:0] fl,
                         input logic [4:0] rd, input logic wr, input logic wf);
        ex_valid    = v;
        ex_result   = res;
        ex_flags    = fl;
        ex_rd       = rd;
        ex_wr_reg   = wr;
        ex_wr_flags = wf;
    endtask

    initial begin
        //            result         flags  rd  wr wf we hit view   q
        vecs[0] = '{32'h0000_1234, 8'h00, 5'd3,  1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00};
        vecs[1] = '{32'hDEAD_BEEF, 8'h05, 5'd7,  1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 8'h05};
        vecs[2] = '{32'h0000_0001, 8'h0F, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h05};
        vecs[3] = '{32'hFFFF_FFFF, 8'h08, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 8'h08, 8'h08};
        vecs[4] = '{32'h8000_0000, 8'h06, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 8'h06, 8'h06};
        vecs[5] = '{32'h0000_0055, 8'hAA, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 8'h06, 8'h06};

        rst_n = 1'b0; flush = 1'b0; wb_grant = 1'b0; fwd_rs = 5'd0;
        drive(1'b0, 32'h0, 8'h0, 5'd0, 1'b0, 1'b0);
        tick(); tick();
        check("rst_ready", 32'(ex_ready), 32'd1);
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_view", 32'(flags_view), 32'h00);
        check("rst_q", 32'(flags_q), 32'h00);
        rst_n = 1'b1;
        tick();

        // Single ops, one at a time, with the write port always granted
        wb_grant = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].result, vecs[i].flags, vecs[i].rd, vecs[i].wr_reg, vecs[i].wr_flags);
            fwd_rs = vecs[i].rd;
            tick();
            ex_valid = 1'b0;
            #1;
            check($sformatf("v%0d_pending", i), 32'(pending), 32'd1);
            check($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d_addr", i), 32'(rf_waddr), 32'(vecs[i].rd));
                check($sformatf("v%0d_data", i), rf_wdata, vecs[i].result);
            end
            check($sformatf("v%0d_hit", i), 32'(fwd_hit), 32'(vecs[i].exp_hit));
            check($sformatf("v%0d_fdata", i), fwd_data, vecs[i].exp_hit ? vecs[i].result : 32'h0);
            check($sformatf("v%0d_view", i), 32'(flags_view), 32'(vecs[i].exp_view));
            tick();
            check($sformatf("v%0d_retired", i), 32'(pending), 32'd0);
            check($sformatf("v%0d_q", i), 32'(flags_q), 32'(vecs[i].exp_q));
        end

        // Simultaneous accept and retire
        drive(1'b1, 32'h99, 8'h00, 5'd9, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'hA0, 8'h00, 5'd10, 1'b1, 1'b0);
        check("sim_addr0", 32'(rf_waddr), 32'd9);
        tick();
        ex_valid = 1'b0;
        check("sim_pending", 32'(pending), 32'd1);
        check("sim_addr1", 32'(rf_waddr), 32'd10);
        check("sim_data1", rf_wdata, 32'hA0);
        tick();
        check("sim_drain", 32'(pending), 32'd0);

        // Backpressure and full
        wb_grant = 1'b0;
        drive(1'b1, 32'h11, 8'h00, 5'd1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h22, 8'h00, 5'd2, 1'b1, 1'b0);
        tick();
        ex_valid = 1'b0;
        check("bp_pending", 32'(pending), 32'd2);
        check("bp_ready", 32'(ex_ready), 32'd0);
        check("bp_we_off", 32'(rf_we), 32'd0);
        wb_grant = 1'b1;
        #1;
        check("bp_we0", 32'(rf_we), 32'd1);
        check("bp_addr0", 32'(rf_waddr), 32'd1);
        check("bp_data0", rf_wdata, 32'h11);
        tick();
        check("bp_ready_back", 32'(ex_ready), 32'd1);
        check("bp_addr1", 32'(rf_waddr), 32'd2);
        check("bp_data1", rf_wdata, 32'h22);
        tick();
        check("bp_drain", 32'(pending), 32'd0);

        // Forwarding, then flush (with a concurrent offer that must be dropped)
        wb_grant = 1'b0;
        drive(1'b1, 32'hAAAA, 8'h00, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'hBBBB, 8'h00, 5'd5, 1'b1, 1'b0);
        tick();
        ex_valid = 1'b0;
        fwd_rs = 5'd5;
        #1;
        check("fwd_hit5", 32'(fwd_hit), 32'd1);
        check("fwd_data5", fwd_data, 32'hBBBB);
        fwd_rs = 5'd0;
        #1;
        check("fwd_hit0", 32'(fwd_hit), 32'd0);
        check("fwd_data0", fwd_data, 32'h0);
        fwd_rs = 5'd6;
        #1;
        check("fwd_hit6", 32'(fwd_hit), 32'd0);
        flush = 1'b1; wb_grant = 1'b1;
        drive(1'b1, 32'hCC, 8'h00, 5'd8, 1'b1, 1'b1);
        #1;
        check("fl_we", 32'(rf_we), 32'd0);
        tick();
        flush = 1'b0; ex_valid = 1'b0;
        check("fl_pending", 32'(pending), 32'd0);
        check("fl_q", 32'(flags_q), 32'h06);

        // Flag view versus committed flags
        wb_grant = 1'b0;
        drive(1'b1, 32'h44, 8'h02, 5'd4, 1'b1, 1'b1);
        tick();
        drive(1'b1, 32'h0, 8'h09, 5'd0, 1'b0, 1'b0);
        tick();
        ex_valid = 1'b0;
        check("fg_view", 32'(flags_view), 32'h02);
        check("fg_q_hold", 32'(flags_q), 32'h06);
        wb_grant = 1'b1;
        tick();
        check("fg_q", 32'(flags_q), 32'h02);
        check("fg_pending", 32'(pending), 32'd1);
        tick();
        check("fg_drain", 32'(pending), 32'd0);
        check("fg_q_keep", 32'(flags_q), 32'h02);

        // r0 writer retires without a grant
        wb_grant = 1'b0;
        drive(1'b1, 32'h77, 8'h00, 5'd0, 1'b1, 1'b0);
        tick();
        ex_valid = 1'b0;
        check("r0_we", 32'(rf_we), 32'd0);
        check("r0_pending", 32'(pending), 32'd1);
        tick();
        check("r0_retired", 32'(pending), 32'd0);

        // Asynchronous reset mid-cycle
        drive(1'b1, 32'h31, 8'h0C, 5'd7, 1'b1, 1'b1);
        tick();
        tick();
        ex_valid = 1'b0;
        fwd_rs = 5'd7;
        #2;
        check("ar_pre_pending", 32'(pending), 32'd2);
        rst_n = 1'b0;
        #1;
        check("ar_pending", 32'(pending), 32'd0);
        check("ar_ready", 32'(ex_ready), 32'd1);
        check("ar_q", 32'(flags_q), 32'h00);
        check("ar_view", 32'(flags_view), 32'h00);
        check("ar_hit", 32'(fwd_hit), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Writeback stage directly downstream of the 32-bit ALU. It accepts each ALU result, ALU flags output, and destination register through a valid/ready handshake, and buffers them in a small in-order queue. Entries retire to the shared register-file write port when the port is granted. The block owns the architected flags register and presents a flag view that feeds back into the ALU `flags_in`. It also provides result forwarding for pending entries to the operand-fetch logic.

## Interface
Parameters:
- `DEPTH`, 2, queue entries (power of two, 2..8)
- `RA_W`, 5, register address width

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  ALU stage presents an op
- `ex_ready`  out  1  stage can accept
- `ex_result`  in  32  ALU result
- `ex_flags`  in  8  ALU flags_out (bit0 C, bit1 Z, bit2 N, bit3 V)
- `ex_rd`  in  RA_W  destination register
- `ex_wr_reg`  in  1  op writes `ex_rd`
- `ex_wr_flags`  in  1  op commits flags
- `flush`  in  1  discard all pending entries
- `wb_grant`  in  1  register-file write port available this cycle
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  RA_W  write address
- `rf_wdata`  out  32  write data
- `flags_q`  out  8  architected flags register
- `flags_view`  out  8  flags after all pending flag writers; drives ALU `flags_in`
- `fwd_rs`  in  RA_W  forwarding lookup address
- `fwd_hit`  out  1  pending entry writes `fwd_rs`
- `fwd_data`  out  32  youngest matching pending result
- `pending`  out  log2(DEPTH)+1  valid entry count

## Operation
- Queue is a circular buffer with head and tail pointers plus a count. Pointers wrap modulo DEPTH.
- **Accept:**
  - `ex_ready` = (count < DEPTH). It is purely registered-state based, with no same-cycle pass-through from a retire.
  - On an edge where `ex_valid & ex_ready & !flush`, the entry {result, flags, rd, wr_reg, wr_flags} is written at the tail.
- **Register-writing head:** a head entry "writes reg" when wr_reg=1 and rd≠0. Register r0 is never written.
- **Retire:** the head retires on an edge when it is valid, `!flush`, and either `wb_grant`=1 or the head does not write reg. Entries with no register write retire without needing `wb_grant`.
- **Register-file outputs** (combinational):
  - `rf_we` = head valid & writes reg & `wb_grant` & `!flush`
  - `rf_waddr` = head rd
  - `rf_wdata` = head result
- **Flag commit:** on retire of an entry with wr_flags=1, `flags_q` ← entry flags (all 8 bits).
- **flags_view:** flags of the youngest valid entry with wr_flags=1; if no such entry exists, `flags_q`.
- **Forwarding:** `fwd_hit` = `fwd_rs`≠0 and any valid entry writes reg with rd=`fwd_rs`. `fwd_data` = result of the youngest such entry, or 0 when there is no hit.
- **Simultaneous accept and retire:** count is unchanged, and both pointers advance.
- **Flush:** synchronous. On the edge it clears count and head/tail pointers. It has priority over accept and retire. In the flush cycle, `rf_we`=0 and no flag commit occurs. `flags_q` is preserved.

## Timing
- **Reset values:**
  - count=0, pointers=0, `flags_q`=8'h00
  - Hence `ex_ready`=1, `rf_we`=0, `fwd_hit`=0, `flags_view`=8'h00, `pending`=0
- **Accept-to-write latency:** an entry accepted at edge N can drive `rf_we` in cycle N+1 at the earliest. It retires at the first subsequent edge meeting the retire condition.
- **Flag latency:** `flags_view` reflects an accepted flag writer in the cycle after acceptance. `flags_q` updates on the retire edge.
- **Full:** `ex_ready` deasserts the cycle after count reaches DEPTH. It reasserts the cycle after a retire.
- **Reset mid-operation:** asynchronous assertion immediately clears all state to the reset values. Pending entries are lost.

## Test plan
- **Reset and single write:** reset, accept {result=0x0000_1234, rd=3, wr_reg=1, wr_flags=1, flags=0x00} with `wb_grant`=1.
  - Next cycle: `rf_we`=1, addr=3, data=0x1234.
  - After that edge: `flags_q`=0x00, `pending`=0.
- **Backpressure:** hold `wb_grant`=0 and accept 2 writers (rd=1, rd=2).
  - `pending`=2, `ex_ready`=0.
  - Grant for 2 cycles: writes rd=1 then rd=2 in order; `ex_ready` returns to 1.
- **Forwarding:** with `wb_grant`=0, queue rd=5←0xAAAA then rd=5←0xBBBB.
  - `fwd_rs`=5 → `fwd_hit`=1, `fwd_data`=0xBBBB.
  - `fwd_rs`=0 → `fwd_hit`=0.
- **Flags:** with `wb_grant`=0, queue flags 0x02 (wr_flags=1), then a wr_flags=0 entry.
  - `flags_view`=0x02 while `flags_q`=0x00.
  - Grant → `flags_q`=0x02.
- **r0 and no-write retire:** accept rd=0 with wr_reg=1 while `wb_grant`=0.
  - Retires next edge; `rf_we` never asserts.
- **Flush and reset:**
  - Queue 2 entries, then assert `flush` with `wb_grant`=1 → `rf_we`=0 that cycle, `pending`=0 next, `flags_q` unchanged.
  - Repeat with async `rst_n` low mid-cycle → outputs at reset values immediately.
